// File: rtl/fixed_sqrt_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fixed_sqrt_if
// Brief    : Handshake bundle for fixed_sqrt_param (input side, result side).
// Revision : 1.0 - initial release
// ============================================================================
interface fixed_sqrt_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x_in;
    logic         round_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sqrt_out;
    logic         exact;
    logic         busy;

    modport master (
        output in_valid, x_in, round_in, out_ready,
        input  in_ready, out_valid, sqrt_out, exact, busy
    );

    modport slave (
        input  in_valid, x_in, round_in, out_ready,
        output in_ready, out_valid, sqrt_out, exact, busy
    );
endinterface
`default_nettype wire

// File: rtl/fixed_sqrt_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fixed_sqrt_param
// Brief    : Unsigned fixed-point square root, restoring, one root bit/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_sqrt_param #(
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  wire logic    clk,
    input  wire logic    rst,
    fixed_sqrt_if.slave  bus
);
    localparam int N     = (W + FRAC + 1) / 2;
    localparam int RAD_W = 2 * N;
    localparam int REM_W = N + 1;
    localparam int T_W   = N + 3;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W:0] C_MAX = {1'b0, {W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RAD_W-1:0]   rad_q, rad_d;
    logic [N-1:0]       root_q, root_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               rnd_q, rnd_d;
    logic [W-1:0]       sqrt_q, sqrt_d;
    logic               exact_q, exact_d;
    logic               out_valid_q, out_valid_d;

    logic               w_in_ready;
    logic               w_accept;
    logic [T_W-1:0]     w_a;
    logic [T_W-1:0]     w_b;
    logic               w_ge;
    logic [T_W-1:0]     w_trial;
    logic [N-1:0]       w_root_nx;
    logic [REM_W-1:0]   w_rem_nx;
    logic               w_inc;
    logic [W:0]         w_sum;
    logic [W-1:0]       w_rounded;

    assign w_in_ready = (state_q == S_IDLE) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;

    // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
    assign w_a       = {rem_q, rad_q[RAD_W-1 -: 2]};
    assign w_b       = {1'b0, root_q, 2'b01};
    assign w_ge      = (w_a >= w_b);
    assign w_trial   = w_ge ? (w_a - w_b) : w_a;
    assign w_root_nx = N'({root_q, w_ge});
    assign w_rem_nx  = REM_W'(w_trial);

    // rem > root means the true root lies above root + 0.5; no tie is possible.
    assign w_inc     = rnd_q && (w_rem_nx > REM_W'(w_root_nx));
    assign w_sum     = (W+1)'(w_root_nx) + (W+1)'(w_inc);
    assign w_rounded = (w_sum > C_MAX) ? C_MAX[W-1:0] : w_sum[W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rad_d       = rad_q;
        root_d      = root_q;
        rem_d       = rem_q;
        rnd_d       = rnd_q;
        sqrt_d      = sqrt_q;
        exact_d     = exact_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_CALC;
                    cnt_d   = CNT_W'(N - 1);
                    rad_d   = RAD_W'(bus.x_in) << FRAC;
                    root_d  = '0;
                    rem_d   = '0;
                    rnd_d   = bus.round_in;
                end
            end
            S_CALC: begin
                rad_d  = rad_q << 2;
                root_d = w_root_nx;
                rem_d  = w_rem_nx;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d       = '0;
                    state_d     = S_DONE;
                    sqrt_d      = w_rounded;
                    exact_d     = (w_rem_nx == '0);
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rad_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            rnd_q       <= 1'b0;
            sqrt_q      <= '0;
            exact_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rad_q       <= rad_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            rnd_q       <= rnd_d;
            sqrt_q      <= sqrt_d;
            exact_q     <= exact_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sqrt_out  = sqrt_q;
    assign bus.exact     = exact_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
